// File: rtl/uart_core_v2_if.sv
// rtl/uart_core_v2_if.sv - configuration, TX/RX handshake and serial pin bundle for uart_core_v2
interface uart_core_v2_if #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
);
  logic [DIV_W-1:0]  BAUD_DIV;
  logic              PAR_EN;
  logic              PAR_TYP;
  logic              STOP2;
  logic [DATA_W-1:0] TX_DATA;
  logic              TX_VALID;
  logic              TX_READY;
  logic              TX_OUT;
  logic              RX_IN;
  logic [DATA_W-1:0] RX_DATA;
  logic              RX_VALID;
  logic              RX_READY;
  logic              RX_PAR_ERR;
  logic              RX_STP_ERR;
  logic              RX_OVR;
  logic              RX_BREAK;

  modport master (
    output BAUD_DIV, PAR_EN, PAR_TYP, STOP2, TX_DATA, TX_VALID, RX_IN, RX_READY,
    input  TX_READY, TX_OUT, RX_DATA, RX_VALID, RX_PAR_ERR, RX_STP_ERR, RX_OVR, RX_BREAK
  );

  modport slave (
    input  BAUD_DIV, PAR_EN, PAR_TYP, STOP2, TX_DATA, TX_VALID, RX_IN, RX_READY,
    output TX_READY, TX_OUT, RX_DATA, RX_VALID, RX_PAR_ERR, RX_STP_ERR, RX_OVR, RX_BREAK
  );
endinterface

// File: rtl/uart_core_v2.sv
// rtl/uart_core_v2.sv - single-clock full-duplex UART, TX/RX valid-ready, overrun, optional break (UART_BREAK_DET_EN)
module uart_core_v2 #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16,
  parameter int DIV_W  = 16
) (
  input  logic          CLK,
  input  logic          rst_n,
  uart_core_v2_if.slave bus
);
  localparam int OW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [OW-1:0] OVS_LAST = OW'(OVS - 1);
  localparam logic [OW-1:0] SMP0     = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] SMP1     = OW'(OVS / 2);
  localparam logic [OW-1:0] SMP2     = OW'(OVS / 2 + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_st_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BRK} rx_st_t;

  // ---------------- TX ----------------
  tx_st_t            tx_st, tx_nx;
  logic [DIV_W-1:0]  tx_div;
  logic [OW-1:0]     tx_ovs;
  logic [BW-1:0]     tx_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic              tx_par_bit, tx_par_en, tx_stop2;
  logic              tx_bit_end, tx_accept, tx_out_c;

  // Each engine owns its prescaler phase so a frame start can realign it.
  assign tx_bit_end = (tx_div == bus.BAUD_DIV) && (tx_ovs == OVS_LAST);
  assign tx_accept  = bus.TX_VALID && (tx_st == T_IDLE);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) tx_st <= T_IDLE;
    else        tx_st <= tx_nx;
  end

  always_comb begin
    tx_nx = tx_st;
    case (tx_st)
      T_IDLE:  if (bus.TX_VALID) tx_nx = T_START;
      T_START: if (tx_bit_end) tx_nx = T_DATA;
      T_DATA:  if (tx_bit_end && tx_cnt == LAST_BIT) tx_nx = tx_par_en ? T_PAR : T_STOP;
      T_PAR:   if (tx_bit_end) tx_nx = T_STOP;
      T_STOP:  if (tx_bit_end && (!tx_stop2 || tx_cnt == BW'(1))) tx_nx = T_IDLE;
      default: tx_nx = T_IDLE;
    endcase
  end

  always_comb begin
    tx_out_c = 1'b1;
    case (tx_st)
      T_START: tx_out_c = 1'b0;
      T_DATA:  tx_out_c = tx_sh[0];
      T_PAR:   tx_out_c = tx_par_bit;
      default: tx_out_c = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      tx_div     <= '0;
      tx_ovs     <= '0;
      tx_cnt     <= '0;
      tx_sh      <= '0;
      tx_par_bit <= 1'b0;
      tx_par_en  <= 1'b0;
      tx_stop2   <= 1'b0;
    end else if (tx_accept) begin
      tx_div     <= '0;
      tx_ovs     <= '0;
      tx_cnt     <= '0;
      tx_sh      <= bus.TX_DATA;
      tx_par_bit <= ^bus.TX_DATA ^ bus.PAR_TYP;
      tx_par_en  <= bus.PAR_EN;
      tx_stop2   <= bus.STOP2;
    end else if (tx_st != T_IDLE) begin
      if (tx_div == bus.BAUD_DIV) begin
        tx_div <= '0;
        tx_ovs <= (tx_ovs == OVS_LAST) ? '0 : tx_ovs + OW'(1);
      end else begin
        tx_div <= tx_div + DIV_W'(1);
      end
      if (tx_bit_end) begin
        if (tx_st == T_DATA) tx_sh <= tx_sh >> 1;
        tx_cnt <= (tx_nx != tx_st) ? '0 : tx_cnt + BW'(1);
      end
    end
  end

  assign bus.TX_OUT   = tx_out_c;
  assign bus.TX_READY = (tx_st == T_IDLE);

  // ---------------- RX ----------------
  rx_st_t            rx_st, rx_nx;
  logic              rx_m, rx_s, rx_prev;
  logic [DIV_W-1:0]  rx_div;
  logic [OW-1:0]     rx_ovs;
  logic [BW-1:0]     rx_cnt;
  logic [DATA_W-1:0] rx_sh;
  logic              r_s0, r_s1, rx_maj;
  logic              rx_par_en, rx_par_typ, rx_perr;
  logic              rx_tick, rx_dec, rx_bit_end, rx_fall;
  logic              rx_brk_hit, rx_done, rx_load, rx_ovr_s;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q, rx_perr_q, rx_serr_q, rx_ovr_q, rx_brk_q;
`ifdef UART_BREAK_DET_EN
  logic              rx_all_low;
`endif

  // rx_prev must be high before a low counts, so a line stuck low never re-triggers.
  assign rx_fall    = rx_prev && !rx_s;
  assign rx_tick    = (rx_div == bus.BAUD_DIV);
  assign rx_dec     = rx_tick && (rx_ovs == SMP2);
  assign rx_bit_end = rx_tick && (rx_ovs == OVS_LAST);
  assign rx_maj     = (r_s0 & r_s1) | (r_s0 & rx_s) | (r_s1 & rx_s);
`ifdef UART_BREAK_DET_EN
  assign rx_brk_hit = rx_all_low && !rx_maj;
`else
  assign rx_brk_hit = 1'b0;
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) rx_st <= R_IDLE;
    else        rx_st <= rx_nx;
  end

  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      R_IDLE:  if (rx_fall) rx_nx = R_START;
      R_START: if (rx_dec && rx_maj) rx_nx = R_IDLE;
               else if (rx_bit_end) rx_nx = R_DATA;
      R_DATA:  if (rx_bit_end && rx_cnt == LAST_BIT) rx_nx = rx_par_en ? R_PAR : R_STOP;
      R_PAR:   if (rx_bit_end) rx_nx = R_STOP;
      R_STOP:  if (rx_dec) rx_nx = rx_brk_hit ? R_BRK : R_IDLE;
      R_BRK:   if (rx_s) rx_nx = R_IDLE;
      default: rx_nx = R_IDLE;
    endcase
  end

  always_comb begin
    rx_done  = (rx_st == R_STOP) && rx_dec && !rx_brk_hit;
    rx_load  = rx_done && (!rx_valid_q || bus.RX_READY);
    rx_ovr_s = rx_done && rx_valid_q && !bus.RX_READY;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      rx_div     <= '0;
      rx_ovs     <= '0;
      rx_cnt     <= '0;
      rx_sh      <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      rx_par_en  <= 1'b0;
      rx_par_typ <= 1'b0;
      rx_perr    <= 1'b0;
`ifdef UART_BREAK_DET_EN
      rx_all_low <= 1'b0;
`endif
    end else begin
      rx_m    <= bus.RX_IN;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
      if (rx_st == R_IDLE) begin
        if (rx_fall) begin
          rx_div     <= '0;
          rx_ovs     <= '0;
          rx_cnt     <= '0;
          rx_par_en  <= bus.PAR_EN;
          rx_par_typ <= bus.PAR_TYP;
          rx_perr    <= 1'b0;
`ifdef UART_BREAK_DET_EN
          rx_all_low <= 1'b1;
`endif
        end
      end else if (rx_st != R_BRK) begin
        if (rx_tick) begin
          rx_div <= '0;
          rx_ovs <= (rx_ovs == OVS_LAST) ? '0 : rx_ovs + OW'(1);
        end else begin
          rx_div <= rx_div + DIV_W'(1);
        end
        if (rx_tick && rx_ovs == SMP0) r_s0 <= rx_s;
        if (rx_tick && rx_ovs == SMP1) r_s1 <= rx_s;
        if (rx_dec) begin
`ifdef UART_BREAK_DET_EN
          rx_all_low <= rx_all_low & ~rx_maj;
`endif
          if (rx_st == R_DATA) rx_sh <= {rx_maj, rx_sh[DATA_W-1:1]};
          if (rx_st == R_PAR)  rx_perr <= rx_maj ^ (^rx_sh) ^ rx_par_typ;
        end
        if (rx_bit_end) rx_cnt <= (rx_nx != rx_st) ? '0 : rx_cnt + BW'(1);
      end
    end
  end

  // Output buffer: a load in the same cycle as a read keeps RX_VALID high with the new word.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_serr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_brk_q   <= 1'b0;
    end else begin
      rx_ovr_q <= rx_ovr_s;
      rx_brk_q <= (rx_st == R_STOP) && rx_dec && rx_brk_hit;
      if (rx_load) begin
        rx_data_q  <= rx_sh;
        rx_valid_q <= 1'b1;
        rx_perr_q  <= rx_par_en && rx_perr;
        rx_serr_q  <= !rx_maj;
      end else if (rx_valid_q && bus.RX_READY) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.RX_DATA    = rx_data_q;
  assign bus.RX_VALID   = rx_valid_q;
  assign bus.RX_PAR_ERR = rx_perr_q;
  assign bus.RX_STP_ERR = rx_serr_q;
  assign bus.RX_OVR     = rx_ovr_q;
  assign bus.RX_BREAK   = rx_brk_q;
endmodule

// File: tb/tb_uart_core_v2.sv
// tb/tb_uart_core_v2.sv - vector table plus scoreboard bench for uart_core_v2 (DATA_W=8, OVS=16, BAUD_DIV=3)
module tb_uart_core_v2;
  localparam int DW   = 8;
  localparam int OVS  = 16;
  localparam int DIVW = 16;
  localparam int BIT  = 64;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       se;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par_en, par_typ, stop2, flip_par, stop_low;
    logic [7:0] exp_data;
    logic       exp_pe, exp_se;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic loop = 1'b0;
  logic rx_drv = 1'b1;
  always #5 clk = ~clk;

  uart_core_v2_if #(.DATA_W(DW), .DIV_W(DIVW)) bus();
  assign bus.RX_IN = loop ? bus.TX_OUT : rx_drv;

  uart_core_v2 #(.DATA_W(DW), .OVS(OVS), .DIV_W(DIVW)) dut (
    .CLK   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   ovr_cnt = 0;
  int   brk_cnt = 0;
  int   valid_seen = 0;
  exp_t sb[$];
  exp_t me;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic se);
    exp_t e;
    e.d = d; e.pe = pe; e.se = se;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 4 * BIT && sb.size() != 0; k++) @(negedge clk);
    chk(name, sb.size(), 0);
  endtask

  task automatic tx_check(input logic [7:0] d, input logic pe, input logic typ, input logic s2);
    logic [15:0] bits;
    int nb, cyc;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    if (pe) bits[9] = ^d ^ typ;
    nb = 10 + int'(pe) + int'(s2);
    @(negedge clk);
    bus.PAR_EN = pe; bus.PAR_TYP = typ; bus.STOP2 = s2;
    bus.TX_DATA = d; bus.TX_VALID = 1'b1;
    @(negedge clk);
    bus.TX_VALID = 1'b0;
    cyc = 0;
    while (bus.TX_READY == 1'b0 && cyc < 2000) begin
      if (cyc % BIT == BIT / 2 && cyc / BIT < nb)
        chk($sformatf("tx_bit%0d_%0h", cyc / BIT, d), bus.TX_OUT, bits[cyc/BIT]);
      cyc++;
      @(negedge clk);
    end
    chk($sformatf("tx_ready_low_%0h", d), cyc, nb * BIT);
  endtask

  task automatic rx_send(input logic [7:0] d, input logic pe, input logic typ, input logic s2,
                         input logic fl, input logic sl);
    logic [11:0] bits;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    nb = 9;
    if (pe) begin bits[nb] = ^d ^ typ ^ fl; nb++; end
    bits[nb] = ~sl; nb++;
    if (s2) begin bits[nb] = 1'b1; nb++; end
    @(negedge clk);
    bus.PAR_EN = pe; bus.PAR_TYP = typ; bus.STOP2 = s2;
    for (int b = 0; b < nb; b++) begin
      rx_drv = bits[b];
      repeat (BIT) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (BIT / 4) @(negedge clk);
  endtask

  initial begin
    int v0, o0, b0;
    vecs[0] = '{8'h55, 0, 0, 0, 0, 0, 8'h55, 0, 0};
    vecs[1] = '{8'h81, 1, 0, 0, 1, 0, 8'h81, 1, 0};
    vecs[2] = '{8'h81, 1, 1, 0, 0, 0, 8'h81, 0, 0};
    vecs[3] = '{8'h3C, 0, 0, 0, 0, 1, 8'h3C, 0, 1};
    vecs[4] = '{8'h00, 1, 1, 1, 0, 0, 8'h00, 0, 0};
    vecs[5] = '{8'hFF, 1, 0, 1, 1, 1, 8'hFF, 1, 1};

    bus.BAUD_DIV = 16'd3; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.STOP2 = 1'b0;
    bus.TX_DATA = '0; bus.TX_VALID = 1'b0; bus.RX_READY = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_out", bus.TX_OUT, 1);
    chk("rst_tx_ready", bus.TX_READY, 1);
    chk("rst_rx_valid", bus.RX_VALID, 0);
    chk("rst_rx_data", bus.RX_DATA, 0);
    chk("rst_errs", {bus.RX_PAR_ERR, bus.RX_STP_ERR, bus.RX_OVR, bus.RX_BREAK}, 0);
    rst_n = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (bus.RX_OVR) ovr_cnt++;
          if (bus.RX_BREAK) brk_cnt++;
          if (bus.RX_VALID && bus.RX_READY) begin
            valid_seen++;
            if (sb.size() == 0) begin
              chk("rx_unexpected_valid", bus.RX_VALID, 0);
            end else begin
              me = sb.pop_front();
              chk("rx_data", bus.RX_DATA, me.d);
              chk("rx_par_err", bus.RX_PAR_ERR, me.pe);
              chk("rx_stp_err", bus.RX_STP_ERR, me.se);
            end
          end
        end
      end
    join_none

    repeat (4) @(negedge clk);
    tx_check(8'hA5, 1, 0, 0);

    loop = 1'b1;
    push(8'h3C, 0, 0);
    tx_check(8'h3C, 1, 1, 1);
    drain("loop_drain");
    loop = 1'b0;
    repeat (BIT) @(negedge clk);

    v0 = valid_seen;
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    chk("glitch_no_valid", valid_seen, v0);

    for (int i = 0; i < 6; i++) begin
      push(vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_se);
      rx_send(vecs[i].data, vecs[i].par_en, vecs[i].par_typ, vecs[i].stop2,
              vecs[i].flip_par, vecs[i].stop_low);
      drain($sformatf("vec%0d_drain", i));
    end

    o0 = ovr_cnt;
    bus.RX_READY = 1'b0;
    push(8'h11, 0, 0);
    rx_send(8'h11, 0, 0, 0, 0, 0);
    rx_send(8'h22, 0, 0, 0, 0, 0);
    chk("ovr_valid_held", bus.RX_VALID, 1);
    chk("ovr_data_kept", bus.RX_DATA, 8'h11);
    chk("ovr_pulse_cycles", ovr_cnt - o0, 1);
    bus.RX_READY = 1'b1;
    drain("ovr_drain");
    @(negedge clk);
    chk("ovr_valid_cleared", bus.RX_VALID, 0);

    b0 = brk_cnt;
    v0 = valid_seen;
    bus.PAR_EN = 1'b0;
`ifndef UART_BREAK_DET_EN
    push(8'h00, 0, 1);
`endif
    rx_drv = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * BIT) @(negedge clk);
`ifdef UART_BREAK_DET_EN
    chk("brk_pulse", brk_cnt - b0, 1);
    chk("brk_no_valid", valid_seen - v0, 0);
`else
    drain("brk_as_data");
    chk("brk_tied_low", brk_cnt - b0, 0);
`endif
    push(8'h5A, 0, 0);
    rx_send(8'h5A, 0, 0, 0, 0, 0);
    drain("post_brk_drain");

    @(negedge clk);
    bus.TX_DATA = 8'h00; bus.TX_VALID = 1'b1;
    @(negedge clk);
    bus.TX_VALID = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_tx_low", bus.TX_OUT, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_out", bus.TX_OUT, 1);
    chk("mid_rst_tx_ready", bus.TX_READY, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_rx_valid", bus.RX_VALID, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
